ps2_mouse_tracker: RTL and testbench
====================================

// Module: ps2_mouse_tracker
// PURPOSE
//   Turns the PS/2 mouse byte stream into absolute cursor coordinates and button
//   levels for the paint canvas (96x64 OLED space).
//   Sits between the PS/2 receiver (byte + strobe) and the paint/colour-selector
//   stage, which consumes mouse_x, mouse_y and mouse_l.
//   Resynchronises on corrupt packets and drops stale partial packets.
// PARAMETERS
//   X_MAX        95         largest legal mouse_x (screen width-1)
//   Y_MAX        63         largest legal mouse_y (screen height-1)
//   X_INIT       48         mouse_x after reset
//   Y_INIT       32         mouse_y after reset
//   TIMEOUT_CYC  2_000_000  max clk_100M cycles between bytes of one packet (20 ms)
//   CLEAR_HOLD   1_000_000  clear_req pulse length in cycles (10 ms); PS2_RCLICK_CLEAR_EN only
// PORTS
//   clk_100M   in   1   system clock, 100 MHz
//   reset_n    in   1   asynchronous, active-low reset
//   rx_byte    in   8   byte from PS/2 receiver
//   rx_valid   in   1   one-cycle strobe, rx_byte valid
//   enable     in   1   1 = commit packets to outputs; 0 = parse but freeze outputs
//   mouse_x    out  12  cursor column, 0..X_MAX
//   mouse_y    out  12  cursor row, 0..Y_MAX (0 = top)
//   mouse_l    out  1   left button level
//   mouse_r    out  1   right button level
//   mouse_m    out  1   middle button level
//   pkt_done   out  1   one-cycle pulse: packet committed
//   sync_err   out  1   one-cycle pulse: byte0 rejected
//   clear_req  out  1   canvas clear request (PS2_RCLICK_CLEAR_EN only, else tied 0)
// BEHAVIOUR
//   Reset (async assert, sync release): FSM=WAIT_B0; mouse_x=X_INIT; mouse_y=Y_INIT;
//     all buttons, pkt_done, sync_err, clear_req = 0; timer = 0.
//   FSM: WAIT_B0 -> WAIT_B1 -> WAIT_B2 -> WAIT_B0; advances only on rx_valid.
//   - WAIT_B0: byte accepted only if bit3 = 1; else sync_err pulses and the FSM stays.
//   - Byte0 fields: [0] L, [1] R, [2] M, [4] X sign, [5] Y sign, [6] X ovf, [7] Y ovf.
//   - Third byte commits a packet in the cycle after its rx_valid:
//     outputs, and pkt_done=1, registered on that edge. Latency = 1 cycle.
//   Arithmetic:
//   - dx = signed 9-bit {b0[4],b1}; dy = signed 9-bit {b0[5],b2}.
//   - Sums are formed in 13-bit signed: nx = x + dx; ny = y - dy (PS/2 +Y is up).
//   - Clamp: <0 -> 0; >MAX -> MAX. Never wraps.
//   - An overflow bit set on an axis -> that axis delta is treated as 0.
//     Buttons still update.
//   Timeout:
//   - Timer counts while in WAIT_B1 or WAIT_B2 and clears on every accepted byte.
//   - Reaching TIMEOUT_CYC -> WAIT_B0 and the partial packet is discarded.
//     No sync_err on timeout.
//   - rx_valid in the same cycle as the timeout: the byte wins, and the timer clears.
//   enable=0: FSM keeps parsing (stays in sync); commit is suppressed.
//     No output change, no pkt_done.
//   Back-to-back rx_valid on consecutive cycles is legal. No byte is dropped.
//   Reset mid-packet: the partial packet is lost. The next byte is treated as byte0.
// CONFIGURATION
//   PS2_RCLICK_CLEAR_EN defined:
//   - A committed packet where R goes 0->1 starts clear_req high for CLEAR_HOLD cycles.
//   - A new rising R while clear_req is high restarts the count.
//   PS2_RCLICK_CLEAR_EN undefined: clear_req is constant 0 and the hold counter is absent.
// STRUCTURE
//   Package ps2_mouse_pkg:
//   - FSM state typedef (WAIT_B0, WAIT_B1, WAIT_B2).
//   - Byte0 bit-index constants (BTN_L, BTN_R, BTN_M, SYNC, XSGN, YSGN, XOVF, YOVF).
//   - Default screen limits.
//   Sub-module mouse_axis_clamp (instanced twice):
//   - Inputs: 12-bit position, 9-bit signed delta, ovf, negate flag, MAX.
//   - Output: clamped next position. Combinational.
//   Top level: FSM, byte registers, timeout timer, output registers, optional clear timer.
// TESTING
//   1. Reset, then packet 08,05,03 -> x=53, y=29, buttons 0; pkt_done 1 cycle after byte 3.
//   2. From reset, packet 18,9C,00 (dx=-100) -> x=0; then 08,FF,00 -> x=95.
//   3. Byte 00 in WAIT_B0 -> sync_err pulse, no state change; following 09,00,00 -> mouse_l=1.
//   4. Bytes 08,05, then idle TIMEOUT_CYC cycles, then 08,01,00 -> x=49 (stale byte dropped).
//   5. Packet 48,7F,00 (X ovf) -> x unchanged; enable=0 with 09,10,00 -> no output change.
//   6. PS2_RCLICK_CLEAR_EN: packet 0A,00,00 -> clear_req high exactly CLEAR_HOLD cycles;
//      reset_n low mid-packet -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse tracker: FSM states, byte0
// field positions, datapath widths and default screen limits.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_t;

    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_M = 2;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned XSGN  = 4;
    localparam int unsigned YSGN  = 5;
    localparam int unsigned XOVF  = 6;
    localparam int unsigned YOVF  = 7;

    localparam int unsigned POS_W   = 12;
    localparam int unsigned DELTA_W = 9;
    localparam int unsigned SUM_W   = 13;

    localparam int unsigned X_MAX_DEF  = 95;
    localparam int unsigned Y_MAX_DEF  = 63;
    localparam int unsigned X_INIT_DEF = 48;
    localparam int unsigned Y_INIT_DEF = 32;

endpackage

// File: rtl/ps2_mouse_tracker_axis_clamp.sv
// One cursor axis: adds (or subtracts) a signed 9-bit PS/2 delta to the current
// position and saturates the result into 0..i_max. Purely combinational.
module mouse_axis_clamp
    import ps2_mouse_pkg::*;
(
    input  logic [POS_W-1:0]          i_pos,
    input  logic signed [DELTA_W-1:0] i_delta,
    input  logic                      i_ovf,
    input  logic                      i_neg,
    input  logic [POS_W-1:0]          i_max,
    output logic [POS_W-1:0]          o_pos_c
);

    logic signed [SUM_W-1:0] w_delta;
    logic signed [SUM_W-1:0] w_base;
    logic signed [SUM_W-1:0] w_limit;
    logic signed [SUM_W-1:0] w_sum;

    // An overflowed axis reports garbage, so it contributes no motion.
    always_comb begin
        w_delta = i_ovf ? '0 : SUM_W'(i_delta);
        w_base  = signed'({1'b0, i_pos});
        w_limit = signed'({1'b0, i_max});
        w_sum   = i_neg ? (w_base - w_delta) : (w_base + w_delta);
        if (w_sum < 0) begin
            o_pos_c = '0;
        end else if (w_sum > w_limit) begin
            o_pos_c = i_max;
        end else begin
            o_pos_c = w_sum[POS_W-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet parser: 3-byte framing with resync and inter-byte timeout,
// clamped absolute cursor and button levels. Optional right-click canvas clear
// pulse is built when PS2_RCLICK_CLEAR_EN is defined.
module ps2_mouse_tracker
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned X_MAX       = X_MAX_DEF,
    parameter int unsigned Y_MAX       = Y_MAX_DEF,
    parameter int unsigned X_INIT      = X_INIT_DEF,
    parameter int unsigned Y_INIT      = Y_INIT_DEF,
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int unsigned CLEAR_HOLD  = 1_000_000
) (
    input  logic             clk_100M,
    input  logic             reset_n,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    input  logic             enable,
    output logic [POS_W-1:0] mouse_x,
    output logic [POS_W-1:0] mouse_y,
    output logic             mouse_l,
    output logic             mouse_r,
    output logic             mouse_m,
    output logic             pkt_done,
    output logic             sync_err,
    output logic             clear_req
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_sync_err;
    logic               w_last;
    logic               w_commit;
    logic [TMR_W-1:0]   r_timer;
    logic               w_tmr_hit;
    logic [7:0]         r_b0;
    logic [7:0]         r_b1;
    logic [POS_W-1:0]   r_mouse_x;
    logic [POS_W-1:0]   r_mouse_y;
    logic               r_mouse_l;
    logic               r_mouse_r;
    logic               r_mouse_m;
    logic               r_pkt_done;
    logic               r_sync_err;
    logic [POS_W-1:0]   w_x_nxt;
    logic [POS_W-1:0]   w_y_nxt;

    assign w_tmr_hit = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WAIT_B0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Framing: a byte always beats a timeout landing in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_sync_err  = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            WAIT_B0: begin
                if (rx_valid) begin
                    if (rx_byte[SYNC]) begin
                        w_state_nxt = WAIT_B1;
                    end else begin
                        w_sync_err = 1'b1;
                    end
                end
            end
            WAIT_B1: begin
                if (rx_valid) begin
                    w_state_nxt = WAIT_B2;
                end else if (w_tmr_hit) begin
                    w_state_nxt = WAIT_B0;
                end
            end
            WAIT_B2: begin
                if (rx_valid) begin
                    w_state_nxt = WAIT_B0;
                    w_last      = 1'b1;
                end else if (w_tmr_hit) begin
                    w_state_nxt = WAIT_B0;
                end
            end
            default: w_state_nxt = WAIT_B0;
        endcase
    end

    assign w_commit = w_last & enable & r_b0[SYNC];

    // Timer runs only while waiting mid-packet; any accepted byte or timeout clears it.
    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if ((w_state_nxt != WAIT_B0) && !rx_valid) begin
            r_timer <= r_timer + TMR_W'(1);
        end else begin
            r_timer <= '0;
        end
    end

    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            r_b0 <= '0;
            r_b1 <= '0;
        end else if (rx_valid) begin
            if ((r_state == WAIT_B0) && rx_byte[SYNC]) begin
                r_b0 <= rx_byte;
            end
            if (r_state == WAIT_B1) begin
                r_b1 <= rx_byte;
            end
        end
    end

    // Byte 2 is used straight off the bus so the commit lands one cycle after it.
    mouse_axis_clamp u_clamp_x (
        .i_pos   (r_mouse_x),
        .i_delta ({r_b0[XSGN], r_b1}),
        .i_ovf   (r_b0[XOVF]),
        .i_neg   (1'b0),
        .i_max   (POS_W'(X_MAX)),
        .o_pos_c (w_x_nxt)
    );

    mouse_axis_clamp u_clamp_y (
        .i_pos   (r_mouse_y),
        .i_delta ({r_b0[YSGN], rx_byte}),
        .i_ovf   (r_b0[YOVF]),
        .i_neg   (1'b1),
        .i_max   (POS_W'(Y_MAX)),
        .o_pos_c (w_y_nxt)
    );

    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            r_mouse_x  <= POS_W'(X_INIT);
            r_mouse_y  <= POS_W'(Y_INIT);
            r_mouse_l  <= 1'b0;
            r_mouse_r  <= 1'b0;
            r_mouse_m  <= 1'b0;
            r_pkt_done <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_pkt_done <= w_commit;
            r_sync_err <= w_sync_err;
            if (w_commit) begin
                r_mouse_x <= w_x_nxt;
                r_mouse_y <= w_y_nxt;
                r_mouse_l <= r_b0[BTN_L];
                r_mouse_r <= r_b0[BTN_R];
                r_mouse_m <= r_b0[BTN_M];
            end
        end
    end

`ifdef PS2_RCLICK_CLEAR_EN
    localparam int unsigned CLR_W = $clog2(CLEAR_HOLD + 1);

    logic             w_r_rise;
    logic [CLR_W-1:0] r_clr_cnt;
    logic             r_clear_req;

    assign w_r_rise = w_commit & r_b0[BTN_R] & ~r_mouse_r;

    // Count holds the remaining high cycles after the current one.
    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_cnt   <= '0;
            r_clear_req <= 1'b0;
        end else if (w_r_rise) begin
            r_clr_cnt   <= CLR_W'(CLEAR_HOLD - 1);
            r_clear_req <= 1'b1;
        end else if (r_clear_req) begin
            if (r_clr_cnt == '0) begin
                r_clear_req <= 1'b0;
            end else begin
                r_clr_cnt <= r_clr_cnt - CLR_W'(1);
            end
        end
    end

    assign clear_req = r_clear_req;
`else
    assign clear_req = 1'b0;
`endif

    assign mouse_x  = r_mouse_x;
    assign mouse_y  = r_mouse_y;
    assign mouse_l  = r_mouse_l;
    assign mouse_r  = r_mouse_r;
    assign mouse_m  = r_mouse_m;
    assign pkt_done = r_pkt_done;
    assign sync_err = r_sync_err;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker; short TIMEOUT_CYC/CLEAR_HOLD keep the
// run brief. Clear-pulse checks follow PS2_RCLICK_CLEAR_EN.
module tb_ps2_mouse_tracker;

    localparam int unsigned T_OUT = 40;
    localparam int unsigned C_HLD = 16;

    logic        clk_100M = 1'b0;
    logic        reset_n  = 1'b0;
    logic [7:0]  rx_byte  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        enable   = 1'b1;
    logic [11:0] mouse_x;
    logic [11:0] mouse_y;
    logic        mouse_l;
    logic        mouse_r;
    logic        mouse_m;
    logic        pkt_done;
    logic        sync_err;
    logic        clear_req;

    int n_cmp = 0;
    int n_err = 0;

    ps2_mouse_tracker #(
        .TIMEOUT_CYC (T_OUT),
        .CLEAR_HOLD  (C_HLD)
    ) dut (
        .clk_100M  (clk_100M),
        .reset_n   (reset_n),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .enable    (enable),
        .mouse_x   (mouse_x),
        .mouse_y   (mouse_y),
        .mouse_l   (mouse_l),
        .mouse_r   (mouse_r),
        .mouse_m   (mouse_m),
        .pkt_done  (pkt_done),
        .sync_err  (sync_err),
        .clear_req (clear_req)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic do_reset;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        enable   = 1'b1;
        @(posedge clk_100M); #1;
        reset_n = 1'b0;
        @(posedge clk_100M); #1;
        reset_n = 1'b1;
    endtask

    // One byte with an idle cycle after it; returns 1 ns after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_100M); #1;
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk_100M); #1;
        rx_valid = 1'b0;
    endtask

    // Three bytes on consecutive cycles; returns 1 ns after the commit edge.
    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        @(posedge clk_100M); #1;
        rx_byte = b0; rx_valid = 1'b1;
        @(posedge clk_100M); #1;
        rx_byte = b1;
        @(posedge clk_100M); #1;
        rx_byte = b2;
        @(posedge clk_100M); #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rx_valid = 1'b0;
        @(posedge clk_100M); #1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({mouse_x, mouse_y} !== {12'd48, 12'd32}) begin
            n_err++; $display("FAIL reset_xy: got %0d,%0d want 48,32", mouse_x, mouse_y);
        end
        n_cmp++;
        if ({mouse_l, mouse_r, mouse_m, pkt_done, sync_err, clear_req} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 000000",
                              {mouse_l, mouse_r, mouse_m, pkt_done, sync_err, clear_req});
        end
        @(posedge clk_100M); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        do_reset();
        send_byte(8'h08);
        send_byte(8'h05);
        n_cmp++;
        if (mouse_x !== 12'd48 || pkt_done !== 1'b0) begin
            n_err++; $display("FAIL basic_early: x=%0d done=%b want 48,0", mouse_x, pkt_done);
        end
        send_byte(8'h03);
        n_cmp++;
        if ({mouse_x, mouse_y} !== {12'd53, 12'd29}) begin
            n_err++; $display("FAIL basic_xy: got %0d,%0d want 53,29", mouse_x, mouse_y);
        end
        n_cmp++;
        if ({pkt_done, mouse_l, mouse_r, mouse_m} !== 4'b1000) begin
            n_err++; $display("FAIL basic_done: got %b want 1000", {pkt_done, mouse_l, mouse_r, mouse_m});
        end
        @(posedge clk_100M); #1;
        n_cmp++;
        if (pkt_done !== 1'b0) begin
            n_err++; $display("FAIL basic_done_pulse: got %b want 0", pkt_done);
        end
    endtask

    task automatic test_clamp;
        do_reset();
        send_pkt(8'h18, 8'h9C, 8'h00);
        n_cmp++;
        if (mouse_x !== 12'd0) begin
            n_err++; $display("FAIL clamp_x_low: got %0d want 0", mouse_x);
        end
        send_pkt(8'h08, 8'hFF, 8'h00);
        n_cmp++;
        if (mouse_x !== 12'd95 || pkt_done !== 1'b1) begin
            n_err++; $display("FAIL clamp_x_high: x=%0d done=%b want 95,1", mouse_x, pkt_done);
        end
        send_pkt(8'h28, 8'h00, 8'h80);
        n_cmp++;
        if (mouse_y !== 12'd63) begin
            n_err++; $display("FAIL clamp_y_bottom: got %0d want 63", mouse_y);
        end
        send_pkt(8'h08, 8'h00, 8'h7F);
        n_cmp++;
        if (mouse_y !== 12'd0) begin
            n_err++; $display("FAIL clamp_y_top: got %0d want 0", mouse_y);
        end
    endtask

    task automatic test_sync;
        do_reset();
        send_byte(8'h00);
        n_cmp++;
        if (sync_err !== 1'b1) begin
            n_err++; $display("FAIL sync_err_pulse: got %b want 1", sync_err);
        end
        @(posedge clk_100M); #1;
        n_cmp++;
        if (sync_err !== 1'b0 || pkt_done !== 1'b0) begin
            n_err++; $display("FAIL sync_err_clear: err=%b done=%b want 0,0", sync_err, pkt_done);
        end
        send_pkt(8'h09, 8'h00, 8'h00);
        n_cmp++;
        if ({mouse_l, pkt_done, mouse_x, mouse_y} !== {1'b1, 1'b1, 12'd48, 12'd32}) begin
            n_err++; $display("FAIL sync_resume: l=%b done=%b x=%0d y=%0d want 1,1,48,32",
                              mouse_l, pkt_done, mouse_x, mouse_y);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        send_byte(8'h08);
        send_byte(8'h05);
        repeat (T_OUT + 2) @(posedge clk_100M);
        #1;
        send_pkt(8'h08, 8'h01, 8'h00);
        n_cmp++;
        if ({mouse_x, mouse_y} !== {12'd49, 12'd32}) begin
            n_err++; $display("FAIL timeout_drop: got %0d,%0d want 49,32", mouse_x, mouse_y);
        end
        // A short idle gap mid-packet must not discard it.
        send_byte(8'h08);
        repeat (T_OUT / 2) @(posedge clk_100M);
        #1;
        send_byte(8'h02);
        send_byte(8'h00);
        n_cmp++;
        if (mouse_x !== 12'd51 || pkt_done !== 1'b1) begin
            n_err++; $display("FAIL timeout_keep: x=%0d done=%b want 51,1", mouse_x, pkt_done);
        end
    endtask

    task automatic test_ovf_enable;
        do_reset();
        send_pkt(8'h4A, 8'h7F, 8'h01);
        n_cmp++;
        if ({mouse_x, mouse_y, mouse_r} !== {12'd48, 12'd31, 1'b1}) begin
            n_err++; $display("FAIL ovf_x: got x=%0d y=%0d r=%b want 48,31,1", mouse_x, mouse_y, mouse_r);
        end
        enable = 1'b0;
        send_pkt(8'h09, 8'h10, 8'h00);
        n_cmp++;
        if ({mouse_x, mouse_l, mouse_r, pkt_done} !== {12'd48, 1'b0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL enable_freeze: x=%0d l=%b r=%b done=%b want 48,0,1,0",
                              mouse_x, mouse_l, mouse_r, pkt_done);
        end
        enable = 1'b1;
        send_pkt(8'h0C, 8'h02, 8'h00);
        n_cmp++;
        if ({mouse_x, mouse_m, mouse_r, pkt_done} !== {12'd50, 1'b1, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL enable_insync: x=%0d m=%b r=%b done=%b want 50,1,0,1",
                              mouse_x, mouse_m, mouse_r, pkt_done);
        end
    endtask

    task automatic test_clear_and_midreset;
        int hi_cnt;
        do_reset();
        send_pkt(8'h0A, 8'h00, 8'h00);
        n_cmp++;
        if (mouse_r !== 1'b1) begin
            n_err++; $display("FAIL clear_rbtn: got %b want 1", mouse_r);
        end
        hi_cnt = 0;
        for (int i = 0; i < int'(C_HLD) + 6; i++) begin
            if (clear_req === 1'b1) hi_cnt++;
            @(posedge clk_100M); #1;
        end
`ifdef PS2_RCLICK_CLEAR_EN
        n_cmp++;
        if (hi_cnt != int'(C_HLD)) begin
            n_err++; $display("FAIL clear_len: got %0d want %0d", hi_cnt, C_HLD);
        end
`else
        n_cmp++;
        if (hi_cnt != 0) begin
            n_err++; $display("FAIL clear_tied: got %0d high cycles want 0", hi_cnt);
        end
`endif
        send_pkt(8'h08, 8'h0A, 8'h00);
        send_byte(8'h08);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({mouse_x, mouse_y, mouse_r, clear_req, pkt_done} !== {12'd48, 12'd32, 3'b000}) begin
            n_err++; $display("FAIL midreset: x=%0d y=%0d r=%b clr=%b done=%b want 48,32,0,0,0",
                              mouse_x, mouse_y, mouse_r, clear_req, pkt_done);
        end
        @(posedge clk_100M); #1;
        reset_n = 1'b1;
        send_pkt(8'h08, 8'h01, 8'h00);
        n_cmp++;
        if ({mouse_x, mouse_y} !== {12'd49, 12'd32}) begin
            n_err++; $display("FAIL midreset_resync: got %0d,%0d want 49,32", mouse_x, mouse_y);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_sync();
        test_timeout();
        test_ovf_enable();
        test_clear_and_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
